alu_exec_responder: RTL and testbench
=====================================

// Module: alu_exec_responder
// PURPOSE
//  Execution-side responder to a reservation station's issue handshake.
//  - Accepts one issued op per handshake: operands, func_sel, rd_phys_addr.
//  - Executes it in one ALU cycle, or over 32 cycles for multiply when MUL is compiled in.
//  - Holds the result and drives it on one CDB channel, stamped with ALU_TAG and the
//    destination physical register, until the CDB arbiter grants it.
// PARAMETERS
//  DATA_WIDTH           32     operand/result width
//  PHYS_REG_ADDR_WIDTH  6      destination physical register address width
//  ALU_TAG              2'b00  tag broadcast with every result; 2'b11 is reserved (means VALID)
// PORTS
//  clk           in   1                    clock, rising edge
//  reset         in   1                    asynchronous, active-low
//  flush         in   1                    synchronous, active-high pipeline flush
//  issue_valid   in   1                    RS presents an op
//  issue_ready   out  1                    responder accepts the op this cycle
//  data_a        in   DATA_WIDTH           operand A
//  data_b        in   DATA_WIDTH           operand B
//  func_sel      in   4                    operation select
//  rd_phys_addr  in   PHYS_REG_ADDR_WIDTH  destination physical register
//  cdb_valid     out  1                    result on CDB
//  cdb_tag       out  2                    = ALU_TAG
//  cdb_data      out  DATA_WIDTH           result
//  cdb_dest_reg  out  PHYS_REG_ADDR_WIDTH  destination physical register of the result
//  cdb_grant     in   1                    arbiter consumed the broadcast this cycle
//  busy          out  1                    state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0 except cdb_tag, which is tied to ALU_TAG; state = IDLE.
//  FSM states: IDLE, EXEC (multi-cycle only), BCAST.
//  issue_ready = (state==IDLE) | (state==BCAST & cdb_grant); it is low while flush=1.
//  An accept (issue_valid & issue_ready) latches data_a, data_b, func_sel and rd_phys_addr.
//  Single-cycle op accepted in cycle N: result registered at N+1; cdb_valid=1 from N+1.
//  In BCAST, cdb_valid, cdb_data and cdb_dest_reg stay stable until the cycle cdb_grant=1.
//  - grant with no new accept: next cycle state=IDLE, cdb_valid=0.
//  - grant with a new single-cycle accept: next cycle state=BCAST with the new result
//    (back-to-back throughput 1/cycle).
//  - grant with a new multi-cycle accept: next cycle state=EXEC, cdb_valid=0.
//  cdb_grant while cdb_valid=0 is ignored.
//  func_sel encoding:
//    0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B, 11 MUL.
//    Codes 12..15 give result 0, single cycle, no error.
//  Shift amount = data_b[4:0]. SLT/SLTU return 1 or 0, zero-extended.
//  Arithmetic wraps modulo 2^DATA_WIDTH. MUL returns the low DATA_WIDTH bits of the product.
//  flush (any state): next cycle state=IDLE, cdb_valid=0, in-flight op dropped.
//    flush has priority over a same-cycle grant and over issue_valid.
//  Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.
// CONFIGURATION
//  Macro ALU_EXEC_RESPONDER_MUL_EN.
//  - Defined: MUL (func_sel 11) is an iterative shift-add over DATA_WIDTH cycles.
//    Accept at N -> EXEC for cycles N+1..N+DATA_WIDTH (counter 0..DATA_WIDTH-1),
//    then cdb_valid from N+DATA_WIDTH+1.
//    issue_ready=0 throughout EXEC.
//  - Undefined: func_sel 11 is treated as codes 12..15 (result 0, single cycle);
//    EXEC state and counter are not generated.
// STRUCTURE
//  Package alu_exec_pkg:
//  - func_sel_e enum (4-bit).
//  - resp_state_e enum {IDLE, EXEC, BCAST}.
//  - localparam TAG_VALID = 2'b11.
//  Sub-module alu_comb_core: purely combinational (a, b, func_sel) -> result for the
//  single-cycle ops. The FSM, operand/result registers and multiplier iteration stay in the top.
// TESTING
//  1. ADD: a=5, b=7, func=0, cdb_grant=1 at N+1 -> cdb_valid at N+1 with data=12,
//     dest=rd_phys_addr, tag=ALU_TAG; cdb_valid=0 at N+2.
//  2. Hold: SUB a=3, b=5, grant withheld 4 cycles -> cdb_data=32'hFFFF_FFFE stable,
//     issue_ready=0 until the grant cycle.
//  3. Back-to-back: SRA a=32'h8000_0000, b=4, then a second op accepted in the grant
//     cycle -> data 32'hF800_0000 then the second result on consecutive cycles.
//  4. Flush in BCAST with grant=1 and issue_valid=1 -> next cycle cdb_valid=0,
//     state IDLE, nothing accepted.
//  5. MUL_EN defined: a=6, b=7, func=11 -> cdb_valid at N+33 with data=42;
//     with the macro undefined -> N+1 with data=0.
//  6. Reset pulse during EXEC or BCAST -> all outputs 0 and issue_ready=1 on the
//     first edge after deassertion.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types for the ALU execution responder: op encoding and FSM states.
// No logic; latency and backpressure are defined by the modules that import it.
// TAG_VALID is the reserved CDB tag and must never be used as ALU_TAG.
package alu_exec_pkg;

    typedef enum logic [3:0] {
        FN_ADD    = 4'd0,
        FN_SUB    = 4'd1,
        FN_SLL    = 4'd2,
        FN_SLT    = 4'd3,
        FN_SLTU   = 4'd4,
        FN_XOR    = 4'd5,
        FN_SRL    = 4'd6,
        FN_SRA    = 4'd7,
        FN_OR     = 4'd8,
        FN_AND    = 4'd9,
        FN_PASS_B = 4'd10,
        FN_MUL    = 4'd11
    } func_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        BCAST = 2'd2
    } resp_state_e;

    localparam logic [1:0] TAG_VALID = 2'b11;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: (a, b, func_sel) -> result.
// Latency: purely combinational. Backpressure: none, the caller registers the result.
module alu_comb_core
    import alu_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            func_sel,
    output logic [DATA_WIDTH-1:0] result
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // MUL and the unused codes fall to the default; the top handles MUL itself.
    always_comb begin
        result = '0;
        case (func_sel_e'(func_sel))
            FN_ADD:    result = a + b;
            FN_SUB:    result = a - b;
            FN_SLL:    result = a << shamt;
            FN_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            FN_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            FN_XOR:    result = a ^ b;
            FN_SRL:    result = a >> shamt;
            FN_SRA:    result = $signed(a) >>> shamt;
            FN_OR:     result = a | b;
            FN_AND:    result = a & b;
            FN_PASS_B: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_responder.sv
// ALU responder: accepts one issued op, executes it, holds the result on the CDB until granted.
// Latency: 1 cycle, or DATA_WIDTH+1 for MUL when ALU_EXEC_RESPONDER_MUL_EN is defined.
// Backpressure: issue_ready only in IDLE or in the grant cycle of BCAST; flush drops everything.
module alu_exec_responder
    import alu_exec_pkg::*;
#(
    parameter int         DATA_WIDTH          = 32,
    parameter int         PHYS_REG_ADDR_WIDTH = 6,
    parameter logic [1:0] ALU_TAG             = 2'b00
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [DATA_WIDTH-1:0]          data_a,
    input  logic [DATA_WIDTH-1:0]          data_b,
    input  logic [3:0]                     func_sel,
    input  logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr,
    output logic                           cdb_valid,
    output logic [1:0]                     cdb_tag,
    output logic [DATA_WIDTH-1:0]          cdb_data,
    output logic [PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg,
    input  logic                           cdb_grant,
    output logic                           busy
);

    resp_state_e                    state;
    resp_state_e                    state_nxt;
    resp_state_e                    start_state;
    logic                           accept;
    logic [DATA_WIDTH-1:0]          alu_res;
    logic [DATA_WIDTH-1:0]          result_q;
    logic [PHYS_REG_ADDR_WIDTH-1:0] dest_q;

    assign cdb_tag = ALU_TAG;
    assign accept  = issue_valid & issue_ready;

    alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .a        (data_a),
        .b        (data_b),
        .func_sel (func_sel),
        .result   (alu_res)
    );

`ifdef ALU_EXEC_RESPONDER_MUL_EN
    localparam int             CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH-1);

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_nxt;
    logic                  mul_done;

    assign start_state = (func_sel_e'(func_sel) == FN_MUL) ? EXEC : BCAST;
    assign acc_nxt     = acc + (mplier[0] ? mcand : '0);
    assign mul_done    = (state == EXEC) && (cnt == CNT_LAST);

    // Shift-add: one multiplier bit per cycle; only low DATA_WIDTH product bits are kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            mcand  <= data_a;
            mplier <= data_b;
            acc    <= '0;
        end else if (state == EXEC) begin
            cnt    <= cnt + 1'b1;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
        end
    end
`else
    assign start_state = BCAST;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = start_state;
`ifdef ALU_EXEC_RESPONDER_MUL_EN
            EXEC:    if (mul_done) state_nxt = BCAST;
`endif
            BCAST:   if (cdb_grant) state_nxt = accept ? start_state : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            dest_q   <= '0;
        end else if (accept) begin
            result_q <= alu_res;
            dest_q   <= rd_phys_addr;
        end
`ifdef ALU_EXEC_RESPONDER_MUL_EN
        else if (mul_done) begin
            result_q <= acc_nxt;
        end
`endif
    end

    // issue_ready is qualified with reset so every output reads 0 while reset is held.
    always_comb begin
        issue_ready  = 1'b0;
        cdb_valid    = 1'b0;
        cdb_data     = '0;
        cdb_dest_reg = '0;
        busy         = (state != IDLE);
        case (state)
            IDLE:  issue_ready = reset & ~flush;
            BCAST: begin
                cdb_valid    = 1'b1;
                cdb_data     = result_q;
                cdb_dest_reg = dest_q;
                issue_ready  = reset & ~flush & cdb_grant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_responder.sv
// Self-checking bench for alu_exec_responder: vector table, corner sequences, random vs model.
module tb_alu_exec_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [3:0]  func_sel;
    logic [5:0]  rd_phys_addr;
    logic        cdb_valid;
    logic [1:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [5:0]  cdb_dest_reg;
    logic        cdb_grant;
    logic        busy;

    int tests = 0;
    int fails = 0;

    alu_exec_responder #(.DATA_WIDTH(32), .PHYS_REG_ADDR_WIDTH(6), .ALU_TAG(2'b00)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .data_a       (data_a),
        .data_b       (data_b),
        .func_sel     (func_sel),
        .rd_phys_addr (rd_phys_addr),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_dest_reg (cdb_dest_reg),
        .cdb_grant    (cdb_grant),
        .busy         (busy)
    );

    always #5 clk = ~clk;

`ifdef ALU_EXEC_RESPONDER_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [5:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  r;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference semantics written straight from the op definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        int unsigned sh;
        longint      sa;
        sh = b[4:0];
        sa = longint'($signed(a));
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return 32'(64'(a) * (64'd1 << sh));
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a / (32'd1 << sh);
            4'd7:  return 32'(sa >>> sh);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return MUL_ON ? 32'(64'(a) * 64'(b)) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f, input logic [5:0] rd);
        issue_valid  = 1'b1;
        data_a       = a;
        data_b       = b;
        func_sel     = f;
        rd_phys_addr = rd;
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        cdb_grant   = 1'b0;
        data_a      = '0;
        data_b      = '0;
        func_sel    = '0;
        rd_phys_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step();
    endtask

    vec_t vecs[12];
    exp_t q[$];

    initial begin
        int lat;
        logic exp_rdy;
        logic [3:0] rf;

        vecs[0]  = '{32'd5,          32'd7,  4'd0,  6'd9,  32'd12};
        vecs[1]  = '{32'd3,          32'd5,  4'd1,  6'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{32'h0000_0001,  32'd31, 4'd2,  6'd2,  32'h8000_0000};
        vecs[3]  = '{32'hFFFF_FFFF,  32'd1,  4'd3,  6'd3,  32'd1};
        vecs[4]  = '{32'hFFFF_FFFF,  32'd1,  4'd4,  6'd4,  32'd0};
        vecs[5]  = '{32'hF0F0_F0F0,  32'hFF00_FF00, 4'd5, 6'd5, 32'h0FF0_0FF0};
        vecs[6]  = '{32'h8000_0000,  32'd36, 4'd6,  6'd6,  32'h0800_0000};
        vecs[7]  = '{32'h8000_0000,  32'd4,  4'd7,  6'd7,  32'hF800_0000};
        vecs[8]  = '{32'hFFFF_FFFF,  32'd1,  4'd0,  6'd63, 32'd0};
        vecs[9]  = '{32'h1234_5678,  32'hDEAD_BEEF, 4'd10, 6'd10, 32'hDEAD_BEEF};
        vecs[10] = '{32'h1234_5678,  32'h1111_1111, 4'd13, 6'd11, 32'd0};
        vecs[11] = '{32'hF0F0_F0F0,  32'h0FF0_0FF0, 4'd9,  6'd12, 32'h00F0_00F0};

        reset = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        cdb_grant = 1'b0;
        data_a = '0;
        data_b = '0;
        func_sel = '0;
        rd_phys_addr = '0;
        #3;
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_data", cdb_data, 32'd0);
        chk("rst_dest", 32'(cdb_dest_reg), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd0);
        chk("rst_tag", 32'(cdb_tag), 32'd0);
        apply_reset();
        chk("post_rst_ready", 32'(issue_ready), 32'd1);

        // Table: accept, check broadcast next cycle, grant, check it clears.
        for (int i = 0; i < 12; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].rd);
            chk($sformatf("vec%0d_ready", i), 32'(issue_ready), 32'd1);
            step();
            issue_valid = 1'b0;
            cdb_grant   = 1'b1;
            chk($sformatf("vec%0d_valid", i), 32'(cdb_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), cdb_data, vecs[i].exp);
            chk($sformatf("vec%0d_dest", i), 32'(cdb_dest_reg), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_tag", i), 32'(cdb_tag), 32'd0);
            step();
            cdb_grant = 1'b0;
            chk($sformatf("vec%0d_clear", i), 32'(cdb_valid), 32'd0);
            chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Hold: grant withheld for 4 cycles.
        drive_op(32'd3, 32'd5, 4'd1, 6'd21);
        step();
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 32'(cdb_valid), 32'd1);
            chk("hold_data", cdb_data, 32'hFFFF_FFFE);
            chk("hold_dest", 32'(cdb_dest_reg), 32'd21);
            chk("hold_ready", 32'(issue_ready), 32'd0);
            step();
        end
        issue_valid = 1'b0;
        cdb_grant = 1'b1;
        #1;
        chk("hold_grant_ready", 32'(issue_ready), 32'd1);
        chk("hold_grant_data", cdb_data, 32'hFFFF_FFFE);
        step();
        cdb_grant = 1'b0;
        chk("hold_done", 32'(cdb_valid), 32'd0);

        // Back-to-back: second op accepted in the grant cycle.
        drive_op(32'h8000_0000, 32'd4, 4'd7, 6'd30);
        step();
        chk("b2b_first", cdb_data, 32'hF800_0000);
        drive_op(32'd100, 32'd23, 4'd0, 6'd31);
        cdb_grant = 1'b1;
        #1;
        chk("b2b_ready", 32'(issue_ready), 32'd1);
        step();
        issue_valid = 1'b0;
        chk("b2b_valid2", 32'(cdb_valid), 32'd1);
        chk("b2b_data2", cdb_data, 32'd123);
        chk("b2b_dest2", 32'(cdb_dest_reg), 32'd31);
        step();
        cdb_grant = 1'b0;
        chk("b2b_clear", 32'(cdb_valid), 32'd0);

        // Flush in BCAST beats grant and issue_valid.
        drive_op(32'd1, 32'd1, 4'd0, 6'd5);
        step();
        drive_op(32'd2, 32'd2, 4'd0, 6'd6);
        cdb_grant = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(issue_ready), 32'd0);
        step();
        flush = 1'b0;
        issue_valid = 1'b0;
        cdb_grant = 1'b0;
        chk("flush_valid", 32'(cdb_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        step();
        chk("flush_nothing", 32'(cdb_valid), 32'd0);

        // MUL latency and result.
        drive_op(32'd6, 32'd7, 4'd11, 6'd17);
        step();
        issue_valid = 1'b0;
        lat = 1;
        while (!cdb_valid && lat < 100) begin
            if (!issue_ready && !busy) break;
            step();
            lat++;
        end
        chk("mul_latency", 32'(lat), MUL_ON ? 32'd33 : 32'd1);
        chk("mul_data", cdb_data, MUL_ON ? 32'd42 : 32'd0);
        chk("mul_dest", 32'(cdb_dest_reg), 32'd17);
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;

        // Reset pulse mid-operation.
        drive_op(32'd9, 32'd9, MUL_ON ? 4'd11 : 4'd0, 6'd40);
        step();
        issue_valid = 1'b0;
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cdb_valid), 32'd0);
        chk("mid_rst_data", cdb_data, 32'd0);
        chk("mid_rst_dest", 32'(cdb_dest_reg), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("after_rst_ready", 32'(issue_ready), 32'd1);
        chk("after_rst_valid", 32'(cdb_valid), 32'd0);
        chk("after_rst_busy", 32'(busy), 32'd0);

        // Random single-cycle traffic against a result-queue model.
        for (int i = 0; i < 400; i++) begin
            chk("rnd_valid", 32'(cdb_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_data", cdb_data, q[0].d);
                chk("rnd_dest", 32'(cdb_dest_reg), 32'(q[0].r));
            end
            rf = 4'($urandom_range(0, 15));
            if (MUL_ON && rf == 4'd11) rf = 4'd10;
            cdb_grant    = 1'($urandom_range(0, 1));
            issue_valid  = 1'($urandom_range(0, 1));
            data_a       = $urandom;
            data_b       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            func_sel     = rf;
            rd_phys_addr = 6'($urandom);
            #1;
            exp_rdy = (q.size() == 0) || cdb_grant;
            chk("rnd_ready", 32'(issue_ready), 32'(exp_rdy));
            if (q.size() != 0 && cdb_grant) void'(q.pop_front());
            if (issue_valid && exp_rdy) q.push_back('{ref_alu(data_a, data_b, rf), rd_phys_addr});
            step();
        end

        issue_valid = 1'b0;
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
